// File: rtl/dbg_ram_editor.sv
// Debug-side byte editor for the 256-byte RAM: loads the byte at the selected
// debug address, lets rotation steps dial a new value, and writes it back with the CPU held.
module dbg_ram_editor #(
  parameter int unsigned LOAD_WAIT = 32'd4,
  parameter int unsigned WR_HOLD   = 32'd100000000
) (
  input  logic       qzt_clk,
  input  logic       reset,
  input  logic       edit_en,
  input  logic       pulse,
  input  logic       direction,
  input  logic       commit,
  input  logic [7:0] addr_in,
  input  logic [7:0] rd_data,
  output logic       wr_en,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic [7:0] edit_value,
  output logic       cpu_hold,
  output logic       busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_EDIT  = 2'd2,
    S_WRITE = 2'd3
  } state_t;

  state_t      state_q;
  logic [31:0] cnt_q;
  logic        pulse_dly_q;
  logic        commit_dly_q;
  logic        edit_en_dly_q;
  logic        pulse_rise_q;
  logic        commit_rise_q;
  logic        edit_en_rise_q;
  logic        dir_q;
  logic        wr_en_q;
  logic [7:0]  wr_addr_q;
  logic [7:0]  wr_data_q;
  logic [7:0]  edit_value_q;
  logic        cpu_hold_q;
  logic        busy_q;

  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign edit_value = edit_value_q;
  assign cpu_hold   = cpu_hold_q;
  assign busy       = busy_q;

  // Edge detectors and editor state machine with registered outputs.
  always_ff @(posedge qzt_clk or posedge reset) begin
    if (reset) begin
      state_q        <= S_IDLE;
      cnt_q          <= 32'd0;
      pulse_dly_q    <= 1'b0;
      commit_dly_q   <= 1'b0;
      edit_en_dly_q  <= 1'b0;
      pulse_rise_q   <= 1'b0;
      commit_rise_q  <= 1'b0;
      edit_en_rise_q <= 1'b0;
      dir_q          <= 1'b0;
      wr_en_q        <= 1'b0;
      wr_addr_q      <= 8'd0;
      wr_data_q      <= 8'd0;
      edit_value_q   <= 8'd0;
      cpu_hold_q     <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      pulse_dly_q    <= pulse;
      commit_dly_q   <= commit;
      edit_en_dly_q  <= edit_en;
      pulse_rise_q   <= pulse & ~pulse_dly_q;
      commit_rise_q  <= commit & ~commit_dly_q;
      edit_en_rise_q <= edit_en & ~edit_en_dly_q;
      dir_q          <= direction;

      case (state_q)
        S_IDLE: begin
          edit_value_q <= rd_data;
          if (edit_en_rise_q) begin
            wr_addr_q  <= addr_in;
            cpu_hold_q <= 1'b1;
            busy_q     <= 1'b1;
            cnt_q      <= 32'd0;
            state_q    <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (cnt_q + 32'd1 >= LOAD_WAIT) begin
            edit_value_q <= rd_data;
            busy_q       <= 1'b0;
            cnt_q        <= 32'd0;
            state_q      <= S_EDIT;
          end else begin
            cnt_q <= cnt_q + 32'd1;
          end
        end
        // Events are prioritised; anything lower in the chain is dropped this cycle.
        S_EDIT: begin
          if (!edit_en_dly_q) begin
            cpu_hold_q <= 1'b0;
            state_q    <= S_IDLE;
          end else if (addr_in != wr_addr_q) begin
            wr_addr_q <= addr_in;
            busy_q    <= 1'b1;
            cnt_q     <= 32'd0;
            state_q   <= S_LOAD;
          end else if (commit_rise_q) begin
            wr_data_q <= edit_value_q;
            wr_en_q   <= 1'b1;
            busy_q    <= 1'b1;
            cnt_q     <= 32'd0;
            state_q   <= S_WRITE;
          end else if (pulse_rise_q) begin
            edit_value_q <= dir_q ? (edit_value_q + 8'd1) : (edit_value_q - 8'd1);
          end
        end
        S_WRITE: begin
          if (cnt_q + 32'd1 >= WR_HOLD) begin
            wr_en_q <= 1'b0;
            busy_q  <= 1'b0;
            cnt_q   <= 32'd0;
            if (!edit_en_dly_q) begin
              cpu_hold_q <= 1'b0;
              state_q    <= S_IDLE;
            end else begin
              state_q <= S_EDIT;
            end
          end else begin
            cnt_q <= cnt_q + 32'd1;
          end
        end
        default: begin
          state_q    <= S_IDLE;
          cnt_q      <= 32'd0;
          wr_en_q    <= 1'b0;
          cpu_hold_q <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dbg_ram_editor.sv
// Directed bench for dbg_ram_editor: table of rotation steps plus hand-written
// sequences for load latency, write window, coincident events and mid-write reset.
module tb_dbg_ram_editor;

  localparam int unsigned LW = 32'd4;
  localparam int unsigned WH = 32'd8;

  logic       qzt_clk = 1'b0;
  logic       reset;
  logic       edit_en;
  logic       pulse;
  logic       direction;
  logic       commit;
  logic [7:0] addr_in;
  logic [7:0] rd_data;
  logic       wr_en;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic [7:0] edit_value;
  logic       cpu_hold;
  logic       busy;

  logic [7:0] ram [256];
  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic       pulse;
    logic       dir;
    logic [7:0] addr;
    int         waits;
    logic [7:0] exp_val;
  } step_t;

  step_t steps [10];

  dbg_ram_editor #(.LOAD_WAIT(LW), .WR_HOLD(WH)) dut (
    .qzt_clk    (qzt_clk),
    .reset      (reset),
    .edit_en    (edit_en),
    .pulse      (pulse),
    .direction  (direction),
    .commit     (commit),
    .addr_in    (addr_in),
    .rd_data    (rd_data),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .edit_value (edit_value),
    .cpu_hold   (cpu_hold),
    .busy       (busy)
  );

  always #5 qzt_clk = ~qzt_clk;

  assign rd_data = ram[addr_in];

  task automatic tick();
    @(posedge qzt_clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h, expected %02h", name, act, exp);
    end
  endtask

  task automatic do_step(input step_t s, input int idx);
    addr_in   = s.addr;
    direction = s.dir;
    pulse     = s.pulse;
    tick();
    pulse = 1'b0;
    repeat (s.waits) tick();
    chk($sformatf("step%0d_value", idx), edit_value, s.exp_val);
    chk($sformatf("step%0d_busy", idx), {7'd0, busy}, 8'd0);
    chk($sformatf("step%0d_wr_en", idx), {7'd0, wr_en}, 8'd0);
    chk($sformatf("step%0d_hold", idx), {7'd0, cpu_hold}, 8'd1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_wr_en"}, {7'd0, wr_en}, 8'd0);
    chk({tag, "_wr_addr"}, wr_addr, 8'd0);
    chk({tag, "_wr_data"}, wr_data, 8'd0);
    chk({tag, "_edit_value"}, edit_value, 8'd0);
    chk({tag, "_cpu_hold"}, {7'd0, cpu_hold}, 8'd0);
    chk({tag, "_busy"}, {7'd0, busy}, 8'd0);
  endtask

  initial begin
    steps[0] = '{1'b1, 1'b1, 8'h10, 3, 8'h3D};
    steps[1] = '{1'b1, 1'b0, 8'h10, 3, 8'h3C};
    steps[2] = '{1'b0, 1'b0, 8'h20, 6, 8'h77};
    steps[3] = '{1'b0, 1'b0, 8'h30, 6, 8'hFE};
    steps[4] = '{1'b1, 1'b1, 8'h30, 3, 8'hFF};
    steps[5] = '{1'b1, 1'b1, 8'h30, 3, 8'h00};
    steps[6] = '{1'b1, 1'b1, 8'h30, 3, 8'h01};
    steps[7] = '{1'b1, 1'b0, 8'h30, 3, 8'h00};
    steps[8] = '{1'b1, 1'b0, 8'h30, 3, 8'hFF};
    steps[9] = '{1'b0, 1'b0, 8'h10, 6, 8'hA5};

    for (int i = 0; i < 256; i++) ram[i] = 8'h00;
    ram[8'h10] = 8'h11;
    ram[8'h20] = 8'h77;
    ram[8'h30] = 8'hFE;

    reset     = 1'b1;
    edit_en   = 1'b0;
    pulse     = 1'b0;
    direction = 1'b0;
    commit    = 1'b0;
    addr_in   = 8'h10;

    #12;
    chk_all_zero("reset");
    tick();
    reset = 1'b0;
    tick();
    tick();
    chk("idle_track", edit_value, 8'h11);
    chk("idle_hold", {7'd0, cpu_hold}, 8'd0);

    // Enter edit mode: hold/busy two edges later, capture after LOAD_WAIT more.
    edit_en = 1'b1;
    tick();
    chk("en_e1_hold", {7'd0, cpu_hold}, 8'd0);
    chk("en_e1_busy", {7'd0, busy}, 8'd0);
    tick();
    chk("en_e2_hold", {7'd0, cpu_hold}, 8'd1);
    chk("en_e2_busy", {7'd0, busy}, 8'd1);
    chk("en_e2_wr_addr", wr_addr, 8'h10);
    ram[8'h10] = 8'h3C;
    tick();
    chk("load_e3_value_held", edit_value, 8'h11);
    chk("load_e3_busy", {7'd0, busy}, 8'd1);
    tick();
    tick();
    chk("load_e5_busy", {7'd0, busy}, 8'd1);
    tick();
    chk("load_e6_busy", {7'd0, busy}, 8'd0);
    chk("load_e6_value", edit_value, 8'h3C);

    for (int i = 0; i < 10; i++) begin
      if (i == 2) ram[8'h10] = 8'hA5;
      do_step(steps[i], i);
    end
    chk("addr_after_reload", wr_addr, 8'h10);
    chk("no_write_yet", wr_data, 8'h00);

    // Commit 0xA5 with pulses, commit and an address change inside the window.
    commit = 1'b1;
    tick();
    chk("wr_e1_wr_en", {7'd0, wr_en}, 8'd0);
    commit = 1'b0;
    for (int k = 2; k <= 11; k++) begin
      if (k == 3) begin pulse = 1'b1; direction = 1'b1; end
      if (k == 4) begin pulse = 1'b0; addr_in = 8'h11; commit = 1'b1; end
      if (k == 5) commit = 1'b0;
      if (k == 7) addr_in = 8'h10;
      tick();
      chk($sformatf("wr_e%0d_wr_en", k), {7'd0, wr_en}, (k <= 9) ? 8'd1 : 8'd0);
      chk($sformatf("wr_e%0d_busy", k), {7'd0, busy}, (k <= 9) ? 8'd1 : 8'd0);
      if (k <= 9) begin
        chk($sformatf("wr_e%0d_addr", k), wr_addr, 8'h10);
        chk($sformatf("wr_e%0d_data", k), wr_data, 8'hA5);
      end
    end
    chk("wr_after_value", edit_value, 8'hA5);
    chk("wr_after_hold", {7'd0, cpu_hold}, 8'd1);

    // Exact pulse latency, then commit and pulse in the same cycle.
    pulse = 1'b1;
    direction = 1'b1;
    tick();
    pulse = 1'b0;
    chk("pulse_e1_value", edit_value, 8'hA5);
    tick();
    chk("pulse_e2_value", edit_value, 8'hA6);
    tick();
    commit = 1'b1;
    pulse  = 1'b1;
    tick();
    commit = 1'b0;
    pulse  = 1'b0;
    tick();
    chk("both_wr_en", {7'd0, wr_en}, 8'd1);
    chk("both_wr_data", wr_data, 8'hA6);
    chk("both_value_during", edit_value, 8'hA6);
    repeat (9) tick();
    chk("both_wr_done", {7'd0, wr_en}, 8'd0);
    chk("both_value_after", edit_value, 8'hA6);

    // Reset during the third write cycle.
    commit = 1'b1;
    tick();
    commit = 1'b0;
    tick();
    tick();
    tick();
    chk("rst_pre_wr_en", {7'd0, wr_en}, 8'd1);
    reset   = 1'b1;
    edit_en = 1'b0;
    #1;
    chk_all_zero("rst_async");
    tick();
    tick();
    reset = 1'b0;
    #1;
    chk_all_zero("rst_release");
    addr_in = 8'h20;
    tick();
    chk("post_track_77", edit_value, 8'h77);
    chk("post_wr_en", {7'd0, wr_en}, 8'd0);
    chk("post_hold", {7'd0, cpu_hold}, 8'd0);
    ram[8'h20] = 8'h5A;
    tick();
    tick();
    chk("post_track_5a", edit_value, 8'h5A);
    chk("post_wr_en_late", {7'd0, wr_en}, 8'd0);
    chk("post_busy", {7'd0, busy}, 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
